mem_wait_ctrl: RTL and testbench

Parametrised single-port synchronous memory with a request/ready/done handshake, a configurable number of wait states and a hardware clear sequence after reset. It is the clocked successor to the flat 16-bit Memory block. It sits between the datapath/control unit and storage, and lets the core model slow memories. Out-of-range addresses are flagged rather than silently aliased.

---
 rtl/mem_wait_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_wait_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_ctrl.sv
// Single-port synchronous memory with a req/ready/done handshake,
// configurable wait states and a zero-fill clear sequence after reset.
// Out-of-range addresses complete with err=1 instead of aliasing.
module mem_wait_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            state;
  logic [PTR_W-1:0]      ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  access;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_inrange;
  logic [PTR_W-1:0]      acc_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  mem_wr;
  logic [PTR_W-1:0]      mem_widx;
  logic [DATA_WIDTH-1:0] mem_wval;

  // Select the access operands: with no wait states the access happens at
  // the accept edge, so it must use the live inputs rather than the latches.
  always_comb begin
    access    = 1'b0;
    acc_we    = lat_we;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    case (state)
      S_IDLE: begin
        if (req && (WAIT_STATES == 0)) begin
          access    = 1'b1;
          acc_we    = we;
          acc_addr  = addr;
          acc_wdata = wdata;
        end
      end
      S_WAIT: begin
        if (cnt == '0) access = 1'b1;
      end
      default: ;
    endcase
    acc_inrange = ({1'b0, acc_addr} < (ADDR_WIDTH + 1)'(DEPTH));
    acc_idx     = acc_addr[PTR_W-1:0];
    rd_word     = mem[acc_idx];
    mem_wr      = 1'b0;
    mem_widx    = acc_idx;
    mem_wval    = acc_wdata;
    if (state == S_CLEAR) begin
      mem_wr   = 1'b1;
      mem_widx = ptr;
      mem_wval = '0;
    end else if (access && acc_we && acc_inrange) begin
      mem_wr = 1'b1;
    end
  end

  // Storage array: single write port shared by the clear sequence and writes.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[mem_widx] <= mem_wval;
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CLEAR;
      ptr       <= '0;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ready     <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == PTR_W'(DEPTH - 1)) begin
            ptr   <= '0;
            state <= S_IDLE;
            ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            ready     <= 1'b0;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              cnt   <= CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          done  <= 1'b0;
          err   <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
      // Completion is shared by the zero-wait and wait-state paths.
      if (access) begin
        done <= 1'b1;
        err  <= ~acc_inrange;
        if (!acc_we) rdata <= acc_inrange ? rd_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Bench for mem_wait_ctrl: two builds (2 wait states and 0 wait states,
// DEPTH=8) checked against a transaction-level memory model.
module tb_mem_wait_ctrl;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [15:0] addr  [2];
  logic [15:0] wdata [2];
  logic        ready [2];
  logic        done  [2];
  logic        err   [2];
  logic [15:0] rdata [2];

  int vectors     = 0;
  int miscompares = 0;
  int ws [2]      = '{2, 0};

  logic [15:0] mm     [2][D];
  logic [15:0] rd_exp [2];

  always #5 clk = ~clk;

  mem_wait_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(D), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ready(ready[0]), .done(done[0]), .rdata(rdata[0]), .err(err[0])
  );

  mem_wait_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(D), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ready(ready[1]), .done(done[1]), .rdata(rdata[1]), .err(err[1])
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < D; a++) mm[i][a] = '0;
      rd_exp[i] = '0;
    end
  endtask

  // One transaction on instance i; checks every cycle until ready returns.
  task automatic do_txn(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
    int n;
    logic oor;
    logic [15:0] old;
    n = 0;
    while (ready[i] !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (ready[i] !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_timeout inst%0d got %b need 1", i, ready[i]);
      return;
    end
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    oor = (a >= 16'(D));
    old = rd_exp[i];
    if (w && !oor) mm[i][a[2:0]] = d;
    if (!w) rd_exp[i] = oor ? 16'h0 : mm[i][a[2:0]];
    for (int j = 0; j <= ws[i] + 1; j++) begin
      @(negedge clk);
      req[i] = 1'b0; we[i] = 1'($urandom); addr[i] = 16'($urandom); wdata[i] = 16'($urandom);
      vectors++;
      if (done[i] !== (j == ws[i])) begin
        miscompares++;
        $display("FAIL done inst%0d cyc%0d got %b need %b", i, j, done[i], (j == ws[i]));
      end
      vectors++;
      if (ready[i] !== (j == ws[i] + 1)) begin
        miscompares++;
        $display("FAIL ready inst%0d cyc%0d got %b need %b", i, j, ready[i], (j == ws[i] + 1));
      end
      vectors++;
      if (rdata[i] !== ((j >= ws[i]) ? rd_exp[i] : old)) begin
        miscompares++;
        $display("FAIL rdata inst%0d addr%h cyc%0d got %h need %h", i, a, j, rdata[i],
                 (j >= ws[i]) ? rd_exp[i] : old);
      end
      vectors++;
      if (err[i] !== ((j == ws[i]) ? oor : 1'b0)) begin
        miscompares++;
        $display("FAIL err inst%0d addr%h cyc%0d got %b need %b", i, a, j, err[i],
                 (j == ws[i]) ? oor : 1'b0);
      end
    end
    req[i] = 1'b0;
  endtask

  task automatic check_clear_window();
    for (int k = 1; k <= D + 1; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (ready[i] !== (k >= D)) begin
          miscompares++;
          $display("FAIL clear_ready inst%0d edge%0d got %b need %b", i, k, ready[i], (k >= D));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({ready[i], done[i], err[i], rdata[i]} !== 19'h0) begin
        miscompares++;
        $display("FAIL reset_outputs inst%0d got %b%b%b %h need 0", i, ready[i], done[i], err[i], rdata[i]);
      end
    end
    rst_n = 1'b1;
    model_reset();
    check_clear_window();
  endtask

  task automatic test_clear_reads();
    for (int a = 0; a < D; a++) do_txn(0, 1'b0, 16'(a), 16'h0);
  endtask

  task automatic test_write_read();
    logic [15:0] tbl [D] = '{16'd5, 16'd0, 16'd0, 16'd7, 16'd6, 16'd0, 16'd0, 16'd0};
    do_txn(0, 1'b1, 16'd0, 16'd5);
    do_txn(0, 1'b1, 16'd4, 16'd6);
    do_txn(0, 1'b1, 16'd3, 16'd7);
    for (int a = 0; a < D; a++) begin
      do_txn(0, 1'b0, 16'(a), 16'h0);
      vectors++;
      if (rdata[0] !== tbl[a]) begin
        miscompares++;
        $display("FAIL write_read addr%0d got %h need %h", a, rdata[0], tbl[a]);
      end
    end
  endtask

  task automatic test_out_of_range();
    do_txn(0, 1'b1, 16'd8, 16'd8);
    do_txn(0, 1'b1, 16'h8004, 16'hDEAD);
    for (int a = 0; a < D; a++) do_txn(0, 1'b0, 16'(a), 16'h0);
    do_txn(0, 1'b0, 16'd9, 16'h0);
    do_txn(0, 1'b0, 16'hFFFF, 16'h0);
    do_txn(0, 1'b0, 16'd4, 16'h0);
  endtask

  task automatic test_overwrite();
    do_txn(0, 1'b1, 16'd4, 16'd9);
    do_txn(0, 1'b1, 16'd5, 16'd9);
    do_txn(0, 1'b0, 16'd3, 16'h0);
    do_txn(0, 1'b0, 16'd4, 16'h0);
    do_txn(0, 1'b0, 16'd5, 16'h0);
  endtask

  // Hold req high: accepts only on ready cycles, one per ws+2 cycles.
  task automatic test_hold_req(input int i);
    int accepts, dones, n, per;
    per = ws[i] + 2;
    accepts = 0; dones = 0; n = 0;
    while (ready[i] !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    req[i] = 1'b1; we[i] = 1'b0; addr[i] = 16'd3;
    rd_exp[i] = mm[i][3];
    for (int c = 0; c < 5 * per; c++) begin
      vectors++;
      if (ready[i] !== ((c % per) == 0)) begin
        miscompares++;
        $display("FAIL hold_ready inst%0d cyc%0d got %b need %b", i, c, ready[i], ((c % per) == 0));
      end
      if (ready[i] === 1'b1) accepts++;
      @(negedge clk);
      if (done[i] === 1'b1) dones++;
    end
    req[i] = 1'b0;
    repeat (per) begin
      @(negedge clk);
      if (done[i] === 1'b1) dones++;
    end
    vectors++;
    if (accepts != 5 || dones != accepts) begin
      miscompares++;
      $display("FAIL hold_counts inst%0d got acc=%0d done=%0d need acc=5 done=5", i, accepts, dones);
    end
    vectors++;
    if (rdata[i] !== rd_exp[i]) begin
      miscompares++;
      $display("FAIL hold_rdata inst%0d got %h need %h", i, rdata[i], rd_exp[i]);
    end
  endtask

  task automatic test_ws0();
    do_txn(1, 1'b1, 16'd1, 16'hA5A5);
    do_txn(1, 1'b0, 16'd1, 16'h0);
    vectors++;
    if (rdata[1] !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL ws0_rdata got %h need a5a5", rdata[1]);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      do_txn(t % 2, 1'($urandom), 16'($urandom_range(0, 11)), 16'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (ready[0] !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'd2; wdata[0] = 16'd3;
    @(negedge clk);
    req[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ready[0], done[0], err[0], rdata[0]} !== 19'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs got %b%b%b %h need 0", ready[0], done[0], err[0], rdata[0]);
    end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (done[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_done got %b need 0", done[0]);
      end
    end
    model_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_clear_window();
    do_txn(0, 1'b0, 16'd2, 16'h0);
    do_txn(1, 1'b0, 16'd1, 16'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    model_reset();
    @(negedge clk);
    test_reset();
    test_clear_reads();
    test_write_read();
    test_out_of_range();
    test_overwrite();
    test_hold_req(0);
    test_ws0();
    test_hold_req(1);
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
